// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM encoding and write-back control layout.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam logic [1:0] WB_BUBBLE = 2'b00;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: master raises mem_req_o with we/addr/wdata and holds them stable until the
  // slave returns a one-cycle mem_ack_i pulse; mem_rdata_i is valid only in that ack cycle.
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a full instruction or a bubble (controls cleared, data held).
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bubble_i,
  input  logic [1:0]        wb_i,
  input  logic [4:0]        rd_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [1:0]        wb_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] mem_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_o  <= WB_BUBBLE;
      rd_o  <= '0;
      alu_o <= '0;
      mem_o <= '0;
    end else if (bubble_i) begin
      wb_o <= WB_BUBBLE;
    end else begin
      wb_o  <= wb_i;
      rd_o  <= rd_i;
      alu_o <= alu_i;
      mem_o <= mem_i;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues variable-latency data-memory accesses, stalls upstream while one is
// outstanding, flags timeouts/misalignment, and feeds the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] data_i,
  mem_access_stage_if.master mem_bus,
  output logic              stall_o,
  output logic [1:0]        WB_o,
  output logic              FW_o,
  output logic [4:0]        RDaddr_o,
  output logic [DATA_W-1:0] ALUdata_o,
  output logic [DATA_W-1:0] MEMdata_o,
  output logic              err_o,
  output mem_state_e        state_o
);

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q;
  logic              req_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cap_q;

  logic              access, aligned;
  logic              stall_c, bubble, start, finish, capture, err_set, cnt_inc;
  logic [DATA_W-1:0] wb_mem_data;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (ALUdata_i[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    bubble      = 1'b1;
    wb_mem_data = cap_q;
    start       = 1'b0;
    finish      = 1'b0;
    capture     = 1'b0;
    err_set     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        wb_mem_data = '0;
        if (access && aligned) begin
          stall_c = 1'b1;
          start   = 1'b1;
          state_d = S_WAIT;
        end else begin
          // Misaligned accesses retire like ALU ops; a store is simply dropped.
          bubble  = 1'b0;
          err_set = access;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (mem_bus.mem_ack_i) begin
          finish  = 1'b1;
          capture = !we_q;
          state_d = S_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          finish  = 1'b1;
          err_set = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        bubble  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= MemWrite_i;
        addr_q  <= ADDR_W'(ALUdata_i);
        wdata_q <= data_i;
        cnt_q   <= '0;
        cap_q   <= '0;
      end
      if (finish)  req_q <= 1'b0;
      if (capture) cap_q <= mem_bus.mem_rdata_i;
      if (cnt_inc) cnt_q <= cnt_q + 8'd1;
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (bubble),
    .wb_i     (WB_i),
    .rd_i     (RDaddr_i),
    .alu_i    (ALUdata_i),
    .mem_i    (wb_mem_data),
    .wb_o     (WB_o),
    .rd_o     (RDaddr_o),
    .alu_o    (ALUdata_o),
    .mem_o    (MEMdata_o)
  );

  assign mem_bus.mem_req_o   = req_q;
  assign mem_bus.mem_we_o    = we_q;
  assign mem_bus.mem_addr_o  = addr_q;
  assign mem_bus.mem_wdata_o = wdata_q;

  // Gated by reset so upstream is never frozen while the stage is held in reset.
  assign stall_o = stall_c & rst_i;
  assign FW_o    = WB_o[WB_REGWRITE];
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected retirements are queued at issue and popped at MEM/WB.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int EW = 72;
  localparam logic [EW-1:0] MASK_ALL = '1;
  localparam logic [EW-1:0] MASK_NO_MEM = {{(EW-DW){1'b1}}, {DW{1'b0}}};

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]    WB_i;
  logic          MemRead_i, MemWrite_i;
  logic [4:0]    RDaddr_i;
  logic [DW-1:0] ALUdata_i, data_i;
  logic          stall_o, FW_o, err_o;
  logic [1:0]    WB_o;
  logic [4:0]    RDaddr_o;
  logic [DW-1:0] ALUdata_o, MEMdata_o;
  mem_state_e    state_o;

  mem_access_stage_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_access_stage #(.MAX_WAIT(MW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .WB_i       (WB_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .RDaddr_i   (RDaddr_i),
    .ALUdata_i  (ALUdata_i),
    .data_i     (data_i),
    .mem_bus    (mem_if),
    .stall_o    (stall_o),
    .WB_o       (WB_o),
    .FW_o       (FW_o),
    .RDaddr_o   (RDaddr_o),
    .ALUdata_o  (ALUdata_o),
    .MEMdata_o  (MEMdata_o),
    .err_o      (err_o),
    .state_o    (state_o)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_ret(input logic [1:0] wb, input logic [4:0] rd,
                                             input logic [DW-1:0] alu, input logic [DW-1:0] md);
    return {wb, wb[0], rd, alu, md};
  endfunction

  task automatic pop_check(input string tag, input logic [EW-1:0] mask);
    logic [EW-1:0] exp, obs;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      obs = {WB_o, FW_o, RDaddr_o, ALUdata_o, MEMdata_o};
      check(tag, 160'(obs & mask), 160'(exp & mask));
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] wb, input logic mr, input logic mw, input logic [4:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] dat);
    WB_i       = wb;
    MemRead_i  = mr;
    MemWrite_i = mw;
    RDaddr_i   = rd;
    ALUdata_i  = alu;
    data_i     = dat;
  endtask

  task automatic run_access(input int ack_at, input int exp_stall, input int exp_req,
                            input logic [AW+DW:0] exp_bus, input logic [DW-1:0] rdata,
                            input logic [EW-1:0] mask, input string tag);
    int stalls = 0;
    int reqs = 0;
    int it = 0;
    #1;
    while (stall_o === 1'b1 && it < 40) begin
      stalls++;
      if (mem_if.mem_req_o === 1'b1) reqs++;
      if (it == 0) begin
        check({tag, " idle_req"}, 160'(mem_if.mem_req_o), 160'(0));
      end else begin
        check({tag, " bus_hold"},
              160'({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_wdata_o, WB_o}),
              160'({1'b1, exp_bus, 2'b00}));
        if (it - 1 == ack_at) begin
          mem_if.mem_ack_i   = 1'b1;
          mem_if.mem_rdata_i = rdata;
        end
      end
      @(negedge clk_i);
      mem_if.mem_ack_i   = 1'b0;
      mem_if.mem_rdata_i = '0;
      it++;
    end
    check({tag, " no_hang"}, 160'(it < 40), 160'(1));
    check({tag, " stall_cycles"}, 160'(stalls), 160'(exp_stall));
    check({tag, " req_cycles"}, 160'(reqs), 160'(exp_req));
    check({tag, " req_dropped"}, 160'(mem_if.mem_req_o), 160'(0));
    @(negedge clk_i);
    pop_check({tag, " retire"}, mask);
  endtask

  initial begin
    drive(2'b00, 1'b0, 1'b0, 5'd0, '0, '0);
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs",
          160'({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_wdata_o, stall_o, err_o,
                WB_o, FW_o, RDaddr_o, ALUdata_o, MEMdata_o}), 160'(0));
    check("reset_state", 160'(state_o), 160'(S_IDLE));
    rst_i = 1'b1;
    @(negedge clk_i);

    // ALU op, no memory access
    drive(2'b01, 1'b0, 1'b0, 5'd5, 32'h10, '0);
    exp_q.push_back(pack_ret(2'b01, 5'd5, 32'h10, '0));
    #1 check("alu stall", 160'(stall_o), 160'(0));
    @(negedge clk_i);
    pop_check("alu retire", MASK_ALL);

    // Load, ack in third WAIT cycle
    drive(2'b11, 1'b1, 1'b0, 5'd7, 32'h40, '0);
    exp_q.push_back(pack_ret(2'b11, 5'd7, 32'h40, 32'hDEADBEEF));
    run_access(2, 4, 3, {1'b0, 32'h40, 32'h0}, 32'hDEADBEEF, MASK_ALL, "load");
    check("load err", 160'(err_o), 160'(0));

    // Store, immediate ack
    drive(2'b00, 1'b0, 1'b1, 5'd0, 32'h8, 32'h1234);
    exp_q.push_back(pack_ret(2'b00, 5'd0, 32'h8, '0));
    run_access(0, 2, 1, {1'b1, 32'h8, 32'h1234}, 32'hCAFEF00D, MASK_NO_MEM, "store");
    check("store err", 160'(err_o), 160'(0));

    // Misaligned load
    drive(2'b11, 1'b1, 1'b0, 5'd3, 32'h42, '0);
    exp_q.push_back(pack_ret(2'b11, 5'd3, 32'h42, '0));
    #1 check("misalign stall", 160'(stall_o), 160'(0));
    @(negedge clk_i);
    pop_check("misalign retire", MASK_ALL);
    check("misalign err", 160'(err_o), 160'(1));
    check("misalign req", 160'(mem_if.mem_req_o), 160'(0));

    // Reset while a request is outstanding
    drive(2'b11, 1'b1, 1'b0, 5'd4, 32'h40, '0);
    @(negedge clk_i);
    check("rstmid req_up", 160'(mem_if.mem_req_o), 160'(1));
    #2 rst_i = 1'b0;
    #1 check("rstmid outputs",
          160'({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_wdata_o, stall_o, err_o,
                WB_o, FW_o, RDaddr_o, ALUdata_o, MEMdata_o}), 160'(0));
    drive(2'b00, 1'b0, 1'b0, 5'd0, '0, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    mem_if.mem_ack_i   = 1'b1;
    mem_if.mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    check("rstmid ack_ignored", 160'({state_o, mem_if.mem_req_o, stall_o, WB_o, MEMdata_o}),
          160'({S_IDLE, 1'b0, 1'b0, 2'b00, 32'h0}));

    // Timeout: load with no ack
    drive(2'b11, 1'b1, 1'b0, 5'd9, 32'h80, '0);
    exp_q.push_back(pack_ret(2'b11, 5'd9, 32'h80, '0));
    run_access(-1, 5, 4, {1'b0, 32'h80, 32'h0}, '0, MASK_ALL, "timeout");
    check("timeout err", 160'(err_o), 160'(1));

    // Pipeline resumes after timeout; error stays sticky
    drive(2'b01, 1'b0, 1'b0, 5'd2, 32'h55, '0);
    exp_q.push_back(pack_ret(2'b01, 5'd2, 32'h55, '0));
    #1 check("resume stall", 160'(stall_o), 160'(0));
    @(negedge clk_i);
    pop_check("resume retire", MASK_ALL);
    check("err sticky", 160'(err_o), 160'(1));
    check("queue drained", 160'(exp_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM register and consumes its WB, M, RDaddr, ALUdata and store-data outputs.
- Drives a variable-latency data-memory request/ack handshake. Asserts stall_o to freeze the EX/MEM register and all earlier stages while an access is outstanding.
- Contains the MEM/WB pipeline register and feeds write-back and the forwarding unit.

Parameters:
- MAX_WAIT, 15, cycles in WAIT without mem_ack_i before timeout (range 1..255).
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- WB_i  in  2  write-back controls from EX/MEM; [0]=RegWrite, [1]=MemtoReg
- MemRead_i  in  1  load in MEM
- MemWrite_i  in  1  store in MEM
- RDaddr_i  in  5  destination register
- ALUdata_i  in  DATA_W  ALU result / memory address
- data_i  in  DATA_W  store data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  ADDR_W  request address
- mem_wdata_o  out  DATA_W  store data
- mem_ack_i  in  1  memory completion, 1-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- stall_o  out  1  freeze upstream pipeline registers
- WB_o  out  2  registered WB controls
- FW_o  out  1  registered RegWrite (WB_o[0]) for forwarding
- RDaddr_o  out  5  registered destination
- ALUdata_o  out  DATA_W  registered ALU result
- MEMdata_o  out  DATA_W  registered load data
- err_o  out  1  sticky error: timeout or misaligned access

Behaviour:
- Reset (async, rst_i=0):
  - FSM to IDLE; wait counter 0.
  - mem_req_o, mem_we_o, stall_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, WB_o, FW_o, RDaddr_o, ALUdata_o, MEMdata_o = 0.
  - Reset mid-access drops mem_req_o immediately. A later mem_ack_i is ignored.
- access = MemRead_i | MemWrite_i. If both are set, the access is a write.
- FSM states:
  - IDLE:
    - No access: stall_o=0. MEM/WB loads inputs at the next edge (latency 1); MEMdata_o=0.
    - Aligned access (ALUdata_i[1:0]==0): stall_o=1 combinationally. At the edge: latch address, data and we into request registers; mem_req_o=1; counter=0; go to WAIT. MEM/WB loads a bubble.
    - Misaligned access: no request, no stall. err_o set. Instruction passes to MEM/WB with MEMdata_o=0; a store has no effect.
  - WAIT:
    - stall_o=1. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable.
    - mem_ack_i=1: capture mem_rdata_i (reads only); drop mem_req_o at the edge; go to DONE.
    - Otherwise the counter increments. When counter==MAX_WAIT-1 with no ack: drop req, set err_o, captured data=0, go to DONE.
    - MEM/WB loads a bubble each cycle.
  - DONE:
    - stall_o=0. At the edge MEM/WB loads WB_i, RDaddr_i, ALUdata_i and the captured data; go to IDLE.
    - The EX/MEM register advances on the same edge, so IDLE next evaluates a new instruction.
- A load/store with ack in the first WAIT cycle occupies 3 cycles with stall_o high for 2.
- Bubble definition: WB_o=0, FW_o=0; RDaddr_o, ALUdata_o, MEMdata_o hold their values.
- mem_ack_i outside WAIT is ignored. mem_ack_i on the timeout cycle counts as a normal ack.
- err_o is cleared only by reset.
- stall_o is combinational from state and inputs. No combinational path from mem_ack_i to stall_o.

Decomposition:
- Shared package mem_stage_pkg:
  - FSM state encoding: IDLE, WAIT, DONE.
  - WB bit indices: WB_REGWRITE=0, WB_MEMTOREG=1.
  - Bubble constant for WB (2'b00).
- Sub-module mem_wb_reg: the MEM/WB output register with load/bubble select and async active-low reset.
- The FSM, wait counter and request registers remain in mem_access_stage.

Test Plan:
- Reset mid-WAIT: rst_i low while mem_req_o=1 -> mem_req_o=0 and all outputs 0 immediately. A mem_ack_i pulse after release is ignored; FSM stays in IDLE.
- ALU op: WB_i=2'b01, RDaddr_i=5, ALUdata_i=0x10, no access -> next edge WB_o=01, FW_o=1, RDaddr_o=5, ALUdata_o=0x10, stall_o never 1.
- Load, ack after 3 cycles with mem_rdata_i=0xDEADBEEF, ALUdata_i=0x40:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=0x40 held stable.
  - stall_o high for 4 cycles; WB_o=00 during the stall.
  - After DONE: MEMdata_o=0xDEADBEEF, WB_o=11.
- Store, immediate ack, ALUdata_i=0x8, data_i=0x1234 -> mem_we_o=1, mem_wdata_o=0x1234. stall_o high exactly 2 cycles; err_o=0.
- Timeout, MAX_WAIT=4, load with no ack -> req high 4 cycles then 0. err_o=1 and remains 1. MEMdata_o=0; pipeline resumes.
- Misaligned load, ALUdata_i=0x42 -> mem_req_o stays 0, stall_o=0, err_o=1, MEMdata_o=0 next edge.
